// File: rtl/l2_snoop_if.sv
// Snoop request/result, local array update, writeback and L1 message signals
// of the L2 snoop responder. The responder uses the slave modport.
interface l2_snoop_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned WAY_W  = 3
);
   logic              snp_valid;
   logic              snp_ready;
   logic [1:0]        snp_op;
   logic [ADDR_W-1:0] snp_addr;

   logic              res_valid;
   logic [1:0]        res;

   logic              upd_valid;
   logic [ADDR_W-1:0] upd_addr;
   logic [WAY_W-1:0]  upd_way;
   logic [1:0]        upd_state;

   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;

   logic              l1_valid;
   logic [1:0]        l1_msg;

   modport master (
      output snp_valid, snp_op, snp_addr, upd_valid, upd_addr, upd_way, upd_state, wb_ready,
      input  snp_ready, res_valid, res, wb_valid, wb_addr, l1_valid, l1_msg
   );

   modport slave (
      input  snp_valid, snp_op, snp_addr, upd_valid, upd_addr, upd_way, upd_state, wb_ready,
      output snp_ready, res_valid, res, wb_valid, wb_addr, l1_valid, l1_msg
   );
endinterface

// File: rtl/l2_snoop_responder.sv
// Snoop-side agent of the L2: tag+MESI lookup, snoop result, MESI transition, L1 message and
// writeback of modified lines. Define SNOOP_STATS_EN to add the stat_hit/stat_hitm/stat_nohit counters.
module l2_snoop_responder #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned OFFSET_W = 6,
   parameter int unsigned INDEX_W  = 14,
   parameter int unsigned WAYS     = 8,
   parameter int unsigned WAY_W    = 3,
   parameter int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
   input  logic        clk,
   input  logic        rst,
   l2_snoop_if.slave   bus
`ifdef SNOOP_STATS_EN
   ,
   output logic [31:0] stat_hit,
   output logic [31:0] stat_hitm,
   output logic [31:0] stat_nohit
`endif
);
   localparam int unsigned SETS = 2 ** INDEX_W;

   localparam logic [1:0] OpRead    = 2'b00;
   localparam logic [1:0] OpInval   = 2'b10;
   localparam logic [1:0] OpRfo     = 2'b11;
   localparam logic [1:0] ResHit    = 2'b00;
   localparam logic [1:0] ResHitm   = 2'b01;
   localparam logic [1:0] ResNohit  = 2'b10;
   localparam logic [1:0] MesiI     = 2'b00;
   localparam logic [1:0] MesiS     = 2'b01;
   localparam logic [1:0] MesiM     = 2'b11;
   localparam logic [1:0] MsgGet    = 2'b01;
   localparam logic [1:0] MsgInv    = 2'b10;
   localparam logic [1:0] MsgGetInv = 2'b11;

   typedef enum logic [1:0] {StIdle, StLookup, StRespond, StWb} state_e;

   state_e             state_q, state_d;
   logic [1:0]         req_op_q, req_op_d;
   logic [TAG_W-1:0]   req_tag_q, req_tag_d;
   logic [INDEX_W-1:0] req_idx_q, req_idx_d;
   logic               hit_q, hit_d;
   logic [WAY_W-1:0]   hit_way_q, hit_way_d;
   logic [1:0]         hit_st_q, hit_st_d;
   logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;

   logic [TAG_W-1:0]   arr_tag_q   [SETS][WAYS];
   logic [1:0]         arr_state_q [SETS][WAYS];

   logic               lk_hit;
   logic [WAY_W-1:0]   lk_way;
   logic [1:0]         lk_st;
   logic               snp_we;
   logic [1:0]         snp_new_st;
   logic               need_wb;
   logic               snp_ready_c, res_valid_c, l1_valid_c, wb_valid_c;
   logic [1:0]         res_c, l1_msg_c;

   logic [INDEX_W-1:0] upd_idx;
   logic [TAG_W-1:0]   upd_tag;
   logic               unused_offsets;

   assign upd_idx        = bus.upd_addr[OFFSET_W +: INDEX_W];
   assign upd_tag        = bus.upd_addr[ADDR_W-1 -: TAG_W];
   assign unused_offsets = ^{bus.snp_addr[OFFSET_W-1:0], bus.upd_addr[OFFSET_W-1:0]};

   // Tag compare over the latched set; the lowest matching valid way wins.
   always_comb begin
      lk_hit = 1'b0;
      lk_way = '0;
      lk_st  = MesiI;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!lk_hit && arr_state_q[req_idx_q][WAY_W'(w)] != MesiI &&
             arr_tag_q[req_idx_q][WAY_W'(w)] == req_tag_q) begin
            lk_hit = 1'b1;
            lk_way = WAY_W'(w);
            lk_st  = arr_state_q[req_idx_q][WAY_W'(w)];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      req_op_d    = req_op_q;
      req_tag_d   = req_tag_q;
      req_idx_d   = req_idx_q;
      hit_d       = hit_q;
      hit_way_d   = hit_way_q;
      hit_st_d    = hit_st_q;
      wb_addr_d   = wb_addr_q;
      snp_ready_c = 1'b0;
      res_valid_c = 1'b0;
      res_c       = ResNohit;
      l1_valid_c  = 1'b0;
      l1_msg_c    = 2'b00;
      wb_valid_c  = 1'b0;
      snp_we      = 1'b0;
      snp_new_st  = MesiI;
      need_wb     = 1'b0;

      unique case (state_q)
         StIdle: begin
            snp_ready_c = 1'b1;
            if (bus.snp_valid) begin
               req_op_d  = bus.snp_op;
               req_tag_d = bus.snp_addr[ADDR_W-1 -: TAG_W];
               req_idx_d = bus.snp_addr[OFFSET_W +: INDEX_W];
               state_d   = StLookup;
            end
         end
         StLookup: begin
            // A concurrent local update holds the lookup so it compares against the new contents.
            if (!bus.upd_valid) begin
               hit_d     = lk_hit;
               hit_way_d = lk_way;
               hit_st_d  = lk_st;
               state_d   = StRespond;
            end
         end
         StRespond: begin
            res_valid_c = 1'b1;
            if (hit_q) begin
               case (req_op_q)
                  OpRead: begin
                     snp_we     = 1'b1;
                     snp_new_st = MesiS;
                     if (hit_st_q == MesiM) begin
                        res_c      = ResHitm;
                        l1_valid_c = 1'b1;
                        l1_msg_c   = MsgGet;
                        need_wb    = 1'b1;
                     end else begin
                        res_c = ResHit;
                     end
                  end
                  OpRfo: begin
                     snp_we     = 1'b1;
                     snp_new_st = MesiI;
                     l1_valid_c = 1'b1;
                     if (hit_st_q == MesiM) begin
                        res_c    = ResHitm;
                        l1_msg_c = MsgGetInv;
                        need_wb  = 1'b1;
                     end else begin
                        res_c    = ResHit;
                        l1_msg_c = MsgInv;
                     end
                  end
                  OpInval: begin
                     snp_we     = 1'b1;
                     snp_new_st = MesiI;
                     res_c      = ResHit;
                     l1_valid_c = 1'b1;
                     l1_msg_c   = MsgInv;
                  end
                  default: ;
               endcase
            end
            // A local update of the very same line takes precedence over the snoop transition.
            if (bus.upd_valid && upd_idx == req_idx_q && bus.upd_way == hit_way_q) begin
               snp_we = 1'b0;
            end
            if (need_wb) begin
               wb_addr_d = {req_tag_q, req_idx_q, {OFFSET_W{1'b0}}};
               state_d   = StWb;
            end else begin
               state_d = StIdle;
            end
         end
         StWb: begin
            wb_valid_c = 1'b1;
            if (bus.wb_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Reset aborts any operation at once, including a pending writeback.
   assign bus.snp_ready = snp_ready_c & ~rst;
   assign bus.res_valid = res_valid_c & ~rst;
   assign bus.res       = rst ? ResNohit : res_c;
   assign bus.l1_valid  = l1_valid_c & ~rst;
   assign bus.l1_msg    = rst ? 2'b00 : l1_msg_c;
   assign bus.wb_valid  = wb_valid_c & ~rst;
   assign bus.wb_addr   = rst ? '0 : wb_addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         req_op_q  <= 2'b00;
         req_tag_q <= '0;
         req_idx_q <= '0;
         hit_q     <= 1'b0;
         hit_way_q <= '0;
         hit_st_q  <= MesiI;
         wb_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         req_op_q  <= req_op_d;
         req_tag_q <= req_tag_d;
         req_idx_q <= req_idx_d;
         hit_q     <= hit_d;
         hit_way_q <= hit_way_d;
         hit_st_q  <= hit_st_d;
         wb_addr_q <= wb_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
               arr_state_q[INDEX_W'(s)][WAY_W'(w)] <= MesiI;
            end
         end
      end else begin
         if (snp_we) begin
            arr_state_q[req_idx_q][hit_way_q] <= snp_new_st;
         end
         if (bus.upd_valid) begin
            arr_state_q[upd_idx][bus.upd_way] <= bus.upd_state;
         end
      end
   end

   // Tags need no reset: an invalid state masks them.
   always_ff @(posedge clk) begin
      if (!rst && bus.upd_valid) begin
         arr_tag_q[upd_idx][bus.upd_way] <= upd_tag;
      end
   end

`ifdef SNOOP_STATS_EN
   logic [31:0] stat_hit_q, stat_hit_d;
   logic [31:0] stat_hitm_q, stat_hitm_d;
   logic [31:0] stat_nohit_q, stat_nohit_d;

   always_comb begin
      stat_hit_d   = stat_hit_q;
      stat_hitm_d  = stat_hitm_q;
      stat_nohit_d = stat_nohit_q;
      if (res_valid_c) begin
         case (res_c)
            ResHit:  if (stat_hit_q != 32'hFFFF_FFFF) stat_hit_d = stat_hit_q + 32'd1;
            ResHitm: if (stat_hitm_q != 32'hFFFF_FFFF) stat_hitm_d = stat_hitm_q + 32'd1;
            default: if (stat_nohit_q != 32'hFFFF_FFFF) stat_nohit_d = stat_nohit_q + 32'd1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hit_q   <= '0;
         stat_hitm_q  <= '0;
         stat_nohit_q <= '0;
      end else begin
         stat_hit_q   <= stat_hit_d;
         stat_hitm_q  <= stat_hitm_d;
         stat_nohit_q <= stat_nohit_d;
      end
   end

   assign stat_hit   = stat_hit_q;
   assign stat_hitm  = stat_hitm_q;
   assign stat_nohit = stat_nohit_q;
`endif
endmodule

// File: tb/tb_l2_snoop_responder.sv
// Randomised snoop/update traffic against a line-level MESI model, plus directed scenarios
// with literal expectations.
module tb_l2_snoop_responder;
   typedef struct packed {
      logic        en;
      logic [31:0] addr;
      logic [2:0]  way;
      logic [1:0]  st;
   } upd_t;

   localparam upd_t NoUpd = '0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   l2_snoop_if #(.ADDR_W(32), .WAY_W(3)) bus ();

`ifdef SNOOP_STATS_EN
   logic [31:0] stat_hit, stat_hitm, stat_nohit;
`endif

   l2_snoop_responder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef SNOOP_STATS_EN
      ,
      .stat_hit   (stat_hit),
      .stat_hitm  (stat_hitm),
      .stat_nohit (stat_nohit)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;
   int cnt_hit = 0, cnt_hitm = 0, cnt_nohit = 0;

   // Line model: key = set*8+way; absent entry means Invalid.
   logic [1:0]  m_state [int];
   logic [11:0] m_tag   [int];

   bit          chk_en;
   bit          exp_ready, exp_res_valid, exp_l1_valid, exp_wb_valid;
   logic [1:0]  exp_res, exp_l1_msg;
   logic [31:0] exp_wb_addr;

   logic [1:0]  obs_res, obs_l1_msg;
   bit          obs_l1_seen, obs_wb_seen;
   logic [31:0] obs_wb_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int key(input logic [31:0] a, input int w);
      return int'(a[19:6]) * 8 + w;
   endfunction

   function automatic void m_write(input logic [31:0] a, input int w, input logic [1:0] st);
      m_state[key(a, w)] = st;
      m_tag[key(a, w)]   = a[31:20];
   endfunction

   function automatic void m_lookup(input logic [31:0] a, output bit hit, output int way,
                                    output logic [1:0] st);
      hit = 0;
      way = 0;
      st  = 2'b00;
      for (int w = 7; w >= 0; w--) begin
         int k;
         k = key(a, w);
         if (m_state.exists(k) && m_state[k] != 2'b00 && m_tag[k] == a[31:20]) begin
            hit = 1;
            way = w;
            st  = m_state[k];
         end
      end
   endfunction

   // MESI response table: result, L1 message, new state, writeback.
   function automatic void predict(input logic [1:0] op, input bit hit, input logic [1:0] st,
                                   output logic [1:0] r, output bit l1v, output logic [1:0] msg,
                                   output logic [1:0] nst, output bit wb);
      r = 2'b10; l1v = 0; msg = 2'b00; nst = st; wb = 0;
      if (hit) begin
         case (op)
            2'b00: begin
               nst = 2'b01;
               if (st == 2'b11) begin r = 2'b01; l1v = 1; msg = 2'b01; wb = 1; end
               else r = 2'b00;
            end
            2'b11: begin
               nst = 2'b00; l1v = 1;
               if (st == 2'b11) begin r = 2'b01; msg = 2'b11; wb = 1; end
               else begin r = 2'b00; msg = 2'b10; end
            end
            2'b10: begin nst = 2'b00; r = 2'b00; l1v = 1; msg = 2'b10; end
            default: ;
         endcase
      end
   endfunction

   function automatic upd_t mk_upd(input logic [31:0] a, input logic [2:0] w, input logic [1:0] s);
      upd_t u;
      u.en = 1'b1; u.addr = a; u.way = w; u.st = s;
      return u;
   endfunction

   function automatic logic [31:0] rnd_addr();
      logic [11:0] tg;
      logic [13:0] idx;
      case ($urandom_range(0, 2))
         0:       tg = 12'h000;
         1:       tg = 12'hABC;
         default: tg = 12'hFFF;
      endcase
      idx = ($urandom_range(0, 1) == 0) ? 14'h0000 : 14'h3FFF;
      return {tg, idx, 6'($urandom)};
   endfunction

   function automatic upd_t rnd_upd(input int pct);
      upd_t u;
      u    = mk_upd(rnd_addr(), 3'($urandom), 2'($urandom));
      u.en = ($urandom_range(0, 99) < pct);
      return u;
   endfunction

   task automatic set_exp(input bit rdy, input bit rv, input logic [1:0] r, input bit l1v,
                          input logic [1:0] m, input bit wbv, input logic [31:0] wba);
      exp_ready = rdy; exp_res_valid = rv; exp_res = r;
      exp_l1_valid = l1v; exp_l1_msg = m; exp_wb_valid = wbv; exp_wb_addr = wba;
   endtask

   task automatic drive_upd(input upd_t u);
      bus.upd_valid = u.en;
      bus.upd_addr  = u.addr;
      bus.upd_way   = u.way;
      bus.upd_state = u.st;
      if (u.en) m_write(u.addr, int'(u.way), u.st);
   endtask

   task automatic idle_upd(input upd_t u);
      @(posedge clk); #1;
      bus.snp_valid = 1'b0;
      drive_upd(u);
      set_exp(1, 0, 2'b10, 0, 2'b00, 0, 32'h0);
   endtask

   task automatic do_snoop(input logic [1:0] op, input logic [31:0] addr, input upd_t a_u,
                           input int stalls, input upd_t s_u, input upd_t r_u,
                           input int wb_hold, input bit rst_wb);
      bit         hit, l1v, wbn;
      int         way;
      logic [1:0] st, r, msg, nst;
      upd_t       su;
      obs_res = 2'b11; obs_l1_seen = 0; obs_l1_msg = 2'b00; obs_wb_seen = 0; obs_wb_addr = '0;
      @(posedge clk); #1;
      bus.snp_valid = 1'b1; bus.snp_op = op; bus.snp_addr = addr;
      drive_upd(a_u);
      set_exp(1, 0, 2'b10, 0, 2'b00, 0, 32'h0);
      su    = s_u;
      su.en = 1'b1;
      for (int i = 0; i < stalls; i++) begin
         @(posedge clk); #1;
         bus.snp_valid = 1'b0; bus.snp_addr = $urandom;
         drive_upd(su);
         set_exp(0, 0, 2'b10, 0, 2'b00, 0, 32'h0);
      end
      @(posedge clk); #1;
      bus.snp_valid = 1'b0;
      drive_upd(NoUpd);
      set_exp(0, 0, 2'b10, 0, 2'b00, 0, 32'h0);
      m_lookup(addr, hit, way, st);
      predict(op, hit, st, r, l1v, msg, nst, wbn);
      @(posedge clk); #1;
      if (hit && op != 2'b01) m_state[key(addr, way)] = nst;
      drive_upd(r_u);
      set_exp(0, 1, r, l1v, msg, 0, 32'h0);
      if (wbn) begin
         for (int i = 0; i <= wb_hold; i++) begin
            @(posedge clk); #1;
            drive_upd(NoUpd);
            if (rst_wb) begin
               rst = 1'b1; bus.wb_ready = 1'b0; chk_en = 0;
               m_state.delete(); m_tag.delete();
               cnt_hit = 0; cnt_hitm = 0; cnt_nohit = 0;
               break;
            end
            bus.wb_ready = (i == wb_hold);
            set_exp(0, 0, 2'b10, 0, 2'b00, 1, {addr[31:6], 6'b0});
         end
      end
      @(posedge clk); #1;
      rst = 1'b0; chk_en = 1; bus.wb_ready = 1'b0;
      drive_upd(NoUpd);
      set_exp(1, 0, 2'b10, 0, 2'b00, 0, 32'h0);
   endtask

   always @(negedge clk) begin
      if (bus.res_valid) obs_res = bus.res;
      if (bus.l1_valid) begin obs_l1_seen = 1; obs_l1_msg = bus.l1_msg; end
      if (bus.wb_valid) begin obs_wb_seen = 1; obs_wb_addr = bus.wb_addr; end
      if (chk_en) begin
         chk("snp_ready", 32'(bus.snp_ready), 32'(exp_ready));
         chk("res_valid", 32'(bus.res_valid), 32'(exp_res_valid));
         chk("l1_valid", 32'(bus.l1_valid), 32'(exp_l1_valid));
         chk("wb_valid", 32'(bus.wb_valid), 32'(exp_wb_valid));
         if (exp_res_valid) begin
            chk("res", 32'(bus.res), 32'(exp_res));
            case (exp_res)
               2'b00:   cnt_hit++;
               2'b01:   cnt_hitm++;
               default: cnt_nohit++;
            endcase
         end
         if (exp_l1_valid) chk("l1_msg", 32'(bus.l1_msg), 32'(exp_l1_msg));
         if (exp_wb_valid) chk("wb_addr", bus.wb_addr, exp_wb_addr);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; chk_en = 0;
      bus.snp_valid = 1'b0; bus.snp_op = 2'b00; bus.snp_addr = '0; bus.wb_ready = 1'b0;
      drive_upd(NoUpd);
      set_exp(0, 0, 2'b10, 0, 2'b00, 0, 32'h0);
      @(posedge clk); #1;
      chk_en = 1;
      @(posedge clk); #1;
      chk("rst_res", 32'(bus.res), 32'h2);
      chk("rst_l1_msg", 32'(bus.l1_msg), 32'h0);
      chk("rst_wb_addr", bus.wb_addr, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      set_exp(1, 0, 2'b10, 0, 2'b00, 0, 32'h0);

      // Empty array read miss.
      do_snoop(2'b00, 32'h1234_5680, NoUpd, 0, NoUpd, NoUpd, 0, 0);
      chk("t1_res", 32'(obs_res), 32'h2);
      chk("t1_l1_seen", 32'(obs_l1_seen), 32'h0);
      chk("t1_wb_seen", 32'(obs_wb_seen), 32'h0);

      // E line read twice, then a write snoop.
      idle_upd(mk_upd(32'h0000_0040, 3'd2, 2'b10));
      do_snoop(2'b00, 32'h0000_0040, NoUpd, 0, NoUpd, NoUpd, 0, 0);
      chk("t2_res_first", 32'(obs_res), 32'h0);
      chk("t2_model_state", 32'(m_state[key(32'h0000_0040, 2)]), 32'h1);
      do_snoop(2'b00, 32'h0000_0040, NoUpd, 0, NoUpd, NoUpd, 0, 0);
      chk("t2_res_second", 32'(obs_res), 32'h0);
      do_snoop(2'b01, 32'h0000_0040, NoUpd, 0, NoUpd, NoUpd, 0, 0);
      chk("t2_write_res", 32'(obs_res), 32'h2);

      // RFO on an M line with a held-off writeback.
      idle_upd(mk_upd(32'hABCD_E000, 3'd5, 2'b11));
      do_snoop(2'b11, 32'hABCD_E000, NoUpd, 0, NoUpd, NoUpd, 3, 0);
      chk("t3_res", 32'(obs_res), 32'h1);
      chk("t3_l1_msg", 32'(obs_l1_msg), 32'h3);
      chk("t3_wb_addr", obs_wb_addr, 32'hABCD_E000);
      do_snoop(2'b00, 32'hABCD_E000, NoUpd, 0, NoUpd, NoUpd, 0, 0);
      chk("t3_reread", 32'(obs_res), 32'h2);

      // Update during lookup invalidates the line being snooped.
      idle_upd(mk_upd(32'h0000_1000, 3'd0, 2'b01));
      do_snoop(2'b10, 32'h0000_1000, NoUpd, 1, mk_upd(32'h0000_1000, 3'd0, 2'b00), NoUpd, 0, 0);
      chk("t4_res", 32'(obs_res), 32'h2);
      chk("t4_l1_seen", 32'(obs_l1_seen), 32'h0);

      // Reset during writeback.
      idle_upd(mk_upd(32'h5555_5540, 3'd1, 2'b11));
      do_snoop(2'b00, 32'h5555_5540, NoUpd, 0, NoUpd, NoUpd, 3, 1);
      chk("t5_res", 32'(obs_res), 32'h1);
      do_snoop(2'b00, 32'h5555_5540, NoUpd, 0, NoUpd, NoUpd, 0, 0);
      chk("t5_after_rst", 32'(obs_res), 32'h2);

      for (int n = 0; n < 250; n++) begin
         int pre;
         int stalls;
         pre    = $urandom_range(0, 2);
         stalls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         for (int j = 0; j < pre; j++) idle_upd(rnd_upd(100));
         do_snoop(2'($urandom), rnd_addr(), rnd_upd(30), stalls, rnd_upd(100), rnd_upd(30),
                  int'($urandom_range(0, 3)), 0);
      end

      @(posedge clk); #1;
`ifdef SNOOP_STATS_EN
      chk("stat_hit", stat_hit, 32'(cnt_hit));
      chk("stat_hitm", stat_hitm, 32'(cnt_hitm));
      chk("stat_nohit", stat_nohit, 32'(cnt_nohit));
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
